// File: rtl/mem_pkg.sv
// Shared definitions for the dual-core data-memory responder:
// FSM encoding, core IDs, word/strobe widths and the byte-merge helper.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = WORD_W / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [STRB_W-1:0] strb_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic word_t apply_strb(input word_t old_w, input word_t new_w, input strb_t strb);
        word_t merged;
        merged = old_w;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes
// to the core that did not win last. last_winner resets to core1.
module rr_arb2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_upd,
    output logic o_sel
);

    logic r_last;
    logic w_sel;

    always_comb begin
        w_sel = CORE0;
        if (i_req0 && i_req1) begin
            w_sel = ~r_last;
        end else if (i_req1) begin
            w_sel = CORE1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= CORE1;
        end else if (i_upd) begin
            r_last <= w_sel;
        end
    end

    assign o_sel = w_sel;

endmodule

// File: rtl/dual_core_mem_responder.sv
// Shared data memory for two cores: round-robin arbitration, one word access
// per grant, registered gnt pulse followed one cycle later by rvalid/rdata.
module dual_core_mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [31:0]       c0_addr,
    input  logic [31:0]       c0_wdata,
    input  logic [3:0]        c0_wstrb,
    output logic              c0_gnt,
    output logic              c0_rvalid,
    output logic [31:0]       c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [31:0]       c1_addr,
    input  logic [31:0]       c1_wdata,
    input  logic [3:0]        c1_wstrb,
    output logic              c1_gnt,
    output logic              c1_rvalid,
    output logic [31:0]       c1_rdata
);

    logic [1:0]    r_state;
    logic          r_win;
    logic          r_c0_gnt;
    logic          r_c1_gnt;
    logic          r_c0_rvalid;
    logic          r_c1_rvalid;
    logic          r_we;
    logic [AW-1:0] r_idx;
    word_t         r_wdata;
    strb_t         r_wstrb;
    word_t         r_rdata;
    word_t         r_mem [MEM_WORDS];

    logic          w_sel;
    logic          w_upd;
    logic [31:0]   w_addr;
    logic          w_unused;

    // Arbitration happens in IDLE and again in RESP so a waiting core is
    // served back-to-back, one access every two cycles.
    assign w_upd  = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && (c0_req || c1_req);
    assign w_addr = (w_sel == CORE1) ? c1_addr : c0_addr;

    // Byte offset and bits above the array index are intentionally dropped.
    assign w_unused = ^{w_addr[31:AW+2], w_addr[1:0]};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req0 (c0_req),
        .i_req1 (c1_req),
        .i_upd  (w_upd),
        .o_sel  (w_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_win       <= CORE0;
            r_c0_gnt    <= 1'b0;
            r_c1_gnt    <= 1'b0;
            r_c0_rvalid <= 1'b0;
            r_c1_rvalid <= 1'b0;
        end else begin
            r_c0_gnt    <= 1'b0;
            r_c1_gnt    <= 1'b0;
            r_c0_rvalid <= 1'b0;
            r_c1_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_upd) begin
                        r_state  <= ST_ACCESS;
                        r_win    <= w_sel;
                        r_c0_gnt <= (w_sel == CORE0);
                        r_c1_gnt <= (w_sel == CORE1);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    r_state     <= ST_RESP;
                    r_c0_rvalid <= (r_win == CORE0);
                    r_c1_rvalid <= (r_win == CORE1);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request latch, array and read register carry no reset; a reset during
    // ACCESS forces IDLE first, so the pending write never commits.
    always_ff @(posedge clk) begin
        if (w_upd) begin
            r_we    <= (w_sel == CORE1) ? c1_we    : c0_we;
            r_idx   <= w_addr[AW+1:2];
            r_wdata <= (w_sel == CORE1) ? c1_wdata : c0_wdata;
            r_wstrb <= (w_sel == CORE1) ? c1_wstrb : c0_wstrb;
        end
        if ((r_state == ST_ACCESS) && !rst) begin
            r_rdata <= r_we ? '0 : r_mem[r_idx];
            if (r_we) begin
                r_mem[r_idx] <= apply_strb(r_mem[r_idx], r_wdata, r_wstrb);
            end
        end
    end

    assign c0_gnt    = r_c0_gnt;
    assign c1_gnt    = r_c1_gnt;
    assign c0_rvalid = r_c0_rvalid;
    assign c1_rvalid = r_c1_rvalid;
    assign c0_rdata  = r_c0_rvalid ? r_rdata : '0;
    assign c1_rdata  = r_c1_rvalid ? r_rdata : '0;

endmodule

// File: tb/tb_dual_core_mem_responder.sv
// Directed bench for dual_core_mem_responder: a vector table of single-core
// accesses plus hand-written tie, streaming and reset-abort sequences.
module tb_dual_core_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c0_req = 1'b0, c0_we = 1'b0;
    logic [31:0] c0_addr = '0, c0_wdata = '0;
    logic [3:0]  c0_wstrb = '0;
    logic        c0_gnt, c0_rvalid;
    logic [31:0] c0_rdata;
    logic        c1_req = 1'b0, c1_we = 1'b0;
    logic [31:0] c1_addr = '0, c1_wdata = '0;
    logic [3:0]  c1_wstrb = '0;
    logic        c1_gnt, c1_rvalid;
    logic [31:0] c1_rdata;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic        core;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    dual_core_mem_responder #(.MEM_WORDS(256), .AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .c0_req    (c0_req),
        .c0_we     (c0_we),
        .c0_addr   (c0_addr),
        .c0_wdata  (c0_wdata),
        .c0_wstrb  (c0_wstrb),
        .c0_gnt    (c0_gnt),
        .c0_rvalid (c0_rvalid),
        .c0_rdata  (c0_rdata),
        .c1_req    (c1_req),
        .c1_we     (c1_we),
        .c1_addr   (c1_addr),
        .c1_wdata  (c1_wdata),
        .c1_wstrb  (c1_wstrb),
        .c1_gnt    (c1_gnt),
        .c1_rvalid (c1_rvalid),
        .c1_rdata  (c1_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_gnt"},    {30'd0, c1_gnt, c0_gnt}, 32'd0);
        chk({name, "_rvalid"}, {30'd0, c1_rvalid, c0_rvalid}, 32'd0);
        chk({name, "_rdata"},  c0_rdata | c1_rdata, 32'd0);
    endtask

    task automatic drive(input logic core, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        if (core) begin
            c1_req = 1'b1; c1_we = we; c1_addr = addr; c1_wdata = wdata; c1_wstrb = wstrb;
        end else begin
            c0_req = 1'b1; c0_we = we; c0_addr = addr; c0_wdata = wdata; c0_wstrb = wstrb;
        end
    endtask

    // Single-core access from IDLE; checks gnt at N+1, rvalid/rdata at N+2.
    task automatic access(input string tag, input logic core, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] exp);
        @(negedge clk);
        drive(core, we, addr, wdata, wstrb);
        @(negedge clk);
        chk({tag, "_gnt"}, {30'd0, c1_gnt, c0_gnt}, core ? 32'd2 : 32'd1);
        chk({tag, "_early_rvalid"}, {30'd0, c1_rvalid, c0_rvalid}, 32'd0);
        c0_req = 1'b0;
        c1_req = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid"}, {30'd0, c1_rvalid, c0_rvalid}, core ? 32'd2 : 32'd1);
        chk({tag, "_rdata"}, core ? c1_rdata : c0_rdata, exp);
        chk({tag, "_other_rdata"}, core ? c0_rdata : c1_rdata, 32'd0);
        chk({tag, "_gnt_clr"}, {30'd0, c1_gnt, c0_gnt}, 32'd0);
        @(negedge clk);
        chk_idle({tag, "_after"});
    endtask

    // Both cores request in the same cycle; core0 must win, core1 follows 2 cycles later.
    task automatic tie(input string tag, input logic [31:0] a0, input logic we0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic we1, input logic [31:0] d1,
                       input logic [31:0] exp0, input logic [31:0] exp1);
        @(negedge clk);
        drive(1'b0, we0, a0, d0, 4'hF);
        drive(1'b1, we1, a1, d1, 4'hF);
        @(negedge clk);
        chk({tag, "_gnt0"}, {30'd0, c1_gnt, c0_gnt}, 32'd1);
        c0_req = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid0"}, {30'd0, c1_rvalid, c0_rvalid, c1_gnt}, 32'd2);
        chk({tag, "_rdata0"}, c0_rdata, exp0);
        @(negedge clk);
        chk({tag, "_gnt1"}, {30'd0, c1_gnt, c0_gnt}, 32'd2);
        c1_req = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid1"}, {30'd0, c1_rvalid, c0_rvalid}, 32'd2);
        chk({tag, "_rdata1"}, c1_rdata, exp1);
        @(negedge clk);
        chk_idle({tag, "_after"});
    endtask

    initial begin
        int n_g;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'h5, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h11BB_33DD};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0055, 4'hF, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0055};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_0003, 32'h0,         4'h0, 32'h0000_0055};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h11BB_33DD};
        vecs[10] = '{1'b0, 1'b0, 32'hFFFF_F010, 32'h0,         4'h0, 32'hDEAD_BEEF};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            access($sformatf("vec%0d", i), vecs[i].core, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].wstrb, vecs[i].exp);
        end

        // Fresh reset so the first tie exercises the reset value of last_winner.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tie("tie_wr", 32'h0, 1'b1, 32'd5, 32'h4, 1'b1, 32'd7, 32'h0, 32'h0);
        access("rd5", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'd5);
        access("rd7", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 32'd7);

        // Both cores stream reads; grants must alternate starting with core0.
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        n_g = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("mutex_gnt", {31'd0, c0_gnt & c1_gnt}, 32'd0);
            chk("mutex_rvalid", {31'd0, c0_rvalid & c1_rvalid}, 32'd0);
            if (c0_gnt || c1_gnt) begin
                chk($sformatf("alt_gnt%0d", n_g), {31'd0, c1_gnt}, n_g % 2);
                n_g++;
                if (n_g == 6) begin
                    c0_req = 1'b0;
                    c1_req = 1'b0;
                end
            end
            if (c0_rvalid) chk("stream_rdata0", c0_rdata, 32'd5);
            if (c1_rvalid) chk("stream_rdata1", c1_rdata, 32'd7);
        end
        chk("stream_grants", n_g, 32'd6);
        @(negedge clk);
        chk_idle("stream_end");

        // Reset during ACCESS of a write: nothing must commit or respond.
        access("pre_wr9", 1'b0, 1'b1, 32'h20, 32'd9, 4'hF, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h20, 32'd1, 4'hF);
        @(negedge clk);
        chk("abort_gnt_seen", {31'd0, c0_gnt}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_idle("abort_drop");
        c0_req = 1'b0;
        @(negedge clk);
        chk_idle("abort_hold");
        rst = 1'b0;
        access("abort_rd9", 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'd9);
        tie("reissue", 32'h20, 1'b1, 32'd1, 32'h20, 1'b0, 32'h0, 32'h0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_core_mem_responder.md
Name: dual_core_mem_responder

Overview:
- Shared data-memory responder for the two-core multicore_processor: the target end of the cores' load/store request interface.
- Each core raises a request; this block arbitrates round-robin, performs the word access on an internal single-port array, and returns a grant pulse plus read data.
- Sits beside core0/core1 at top level, replacing per-core private data memories, so both cores see one coherent address space.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the array (power of two).
- AW, 8, word-index width, equal to log2(MEM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- c0_req  in  1  core0 access request, held until granted.
- c0_we  in  1  core0 write enable (0 = load).
- c0_addr  in  32  core0 byte address.
- c0_wdata  in  32  core0 store data.
- c0_wstrb  in  4  core0 byte enables for stores.
- c0_gnt  out  1  one-cycle pulse: core0 request accepted.
- c0_rvalid  out  1  one-cycle pulse: core0 response valid.
- c0_rdata  out  32  core0 load data, valid with c0_rvalid.
- c1_req, c1_we, c1_addr, c1_wdata, c1_wstrb, c1_gnt, c1_rvalid, c1_rdata: identical for core1.

Behaviour:
- Reset (async): all outputs 0; state IDLE; last_winner = 1, so core0 wins the first tie. Array contents are not reset.
- Reset mid-operation: the in-flight access is abandoned with no gnt/rvalid. A write already committed at a past edge stays committed.
- FSM states:
  - IDLE: if any req sampled at the edge, latch the winner's we/addr/wdata/wstrb, go to ACCESS.
  - ACCESS: winner's gnt = 1 (registered). The array is read or written at the edge ending this cycle. Go to RESP.
  - RESP: winner's rvalid = 1. rdata = pre-write word for reads; 0 for writes, where rvalid is the write ack. If the other core's req is high, arbitrate and go to ACCESS; else go to IDLE.
- Latency: req seen at edge N → gnt during cycle N+1 → rvalid during cycle N+2. Back-to-back throughput is one access per 2 cycles.
- Requester rules:
  - Hold req and all fields stable until gnt is sampled high.
  - Drop req the cycle after gnt unless issuing a new access.
  - A req still high in RESP from the core just served is a new request and is arbitrated normally.
- Arbitration:
  - Single requester always wins.
  - On a tie, the core that was not last_winner wins.
  - last_winner updates on each grant.
- Address: word index = addr[AW+1:2]; addr[1:0] ignored (no misalign fault); bits above AW+1 ignored, so accesses wrap modulo MEM_WORDS.
- Writes: only bytes with wstrb[i]=1 are updated; wstrb = 0 is a legal no-op write that still gets gnt/rvalid.
- Only one of c0_gnt/c1_gnt is high in any cycle; the same holds for rvalid.
- rdata is held 0 when rvalid is low.

Decomposition:
- Shared package mem_pkg:
  - FSM state encoding (IDLE, ACCESS, RESP).
  - Core ID constants CORE0 = 0, CORE1 = 1.
  - Word and strobe widths.
- Sub-module rr_arb2:
  - Two request inputs, grant-select output, last_winner register with async reset.
  - Update enable from the FSM.
- Array, FSM and response muxing stay in the top.

Test Plan:
- Core0 stores 0xDEADBEEF at 0x10 with wstrb = 1111, then loads 0x10 → gnt at N+1, rvalid at N+2, rdata = 0xDEADBEEF; core1 outputs stay 0.
- Both cores request in the same cycle after reset (core0 writes 5 @0x0, core1 writes 7 @0x4) → core0 granted first, core1 granted 2 cycles later; reads return 5 and 7.
- Both cores hold req continuously for 6 accesses → grants alternate c0, c1, c0, c1, c0, c1, and no overlapping gnt/rvalid.
- Store 0x11223344, then store 0xAABBCCDD with wstrb = 0101 to the same address → load returns 0x11BB33DD.
- With MEM_WORDS = 256, store 0x55 to addr 0x400, then load addr 0x0 → rdata = 0x55 (wrap); load addr 0x3 → 0x55 (low bits ignored).
- Assert rst during ACCESS of a write to 0x20 (old value 9, new value 1) → gnt/rvalid drop to 0 immediately; after release, load 0x20 returns 9. Then reissue the write → it completes normally with core0 tie priority restored.
